// File: rtl/pps_pkg.sv
// Shared definitions for the PPS pulse shaper: clock rate, FSM encoding and
// the counter-width helper used to size every down/up counter.
package pps_pkg;

  localparam int CLK_HZ = 25_000_000;

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } state_t;

  // Bits needed to hold values 0..n-1; never returns less than 1 so that a
  // one-cycle configuration still gets a legal vector width.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/pps_edge_detect.sv
// Single input register for the raw tick plus a one-cycle rising-edge strobe.
module pps_edge_detect
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise
);

  logic r_q;
  logic r_qq;

  // Register the tick once, then keep a delayed copy for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q  <= 1'b0;
      r_qq <= 1'b0;
    end else begin
      r_q  <= i_d;
      r_qq <= r_q;
    end
  end

  assign o_rise = r_q & ~r_qq;

endmodule

// File: rtl/pps_pulse_shaper.sv
// PPS pulse shaper: regenerates the raw timer tick as a fixed-width o_pps
// pulse, stretches it onto o_led, and counts accepted pulses.
// Optional period watchdog (o_missing / o_early) is built when the macro
// PPS_WATCHDOG_EN is defined; otherwise those outputs are tied low.
module pps_pulse_shaper
  import pps_pkg::*;
#(
  parameter int PULSE_CYC  = 25,
  parameter int PERIOD_CYC = 1750,
  parameter int TOL_CYC    = 25,
  parameter int LED_CYC    = 2500000,
  parameter int CNT_W      = 16
)
(
  input  logic             i_clk_25MHz,
  input  logic             i_rst_n,
  input  logic             i_tick,
  output logic             o_pps,
  output logic             o_led,
  output logic [CNT_W-1:0] o_count,
  output logic             o_missing,
  output logic             o_early
);

  localparam int WID_W = clog2(PULSE_CYC);
  localparam int LED_W = clog2(LED_CYC);

  logic             w_rise;
  logic             w_accept;

  state_t           r_state;
  logic [WID_W-1:0] r_wid_cnt;
  logic             r_pps;
  logic [CNT_W-1:0] r_count;
  logic [LED_W-1:0] r_led_cnt;
  logic             r_led_on;

  pps_edge_detect u_edge (
    .i_clk   (i_clk_25MHz),
    .i_rst_n (i_rst_n),
    .i_d     (i_tick),
    .o_rise  (w_rise)
  );

  // Only a rise seen while idle starts a pulse; rises during a pulse are dropped.
  assign w_accept = (r_state == IDLE) & w_rise;

  // Pulse FSM: width counter, registered o_pps and accepted-pulse counter.
  always_ff @(posedge i_clk_25MHz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_wid_cnt <= '0;
      r_pps     <= 1'b0;
      r_count   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state   <= PULSE;
            r_wid_cnt <= WID_W'(PULSE_CYC - 1);
            r_pps     <= 1'b1;
            r_count   <= r_count + 1'b1;
          end
        end
        PULSE: begin
          if (r_wid_cnt == '0) begin
            r_state <= IDLE;
            r_pps   <= 1'b0;
          end else begin
            r_wid_cnt <= r_wid_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_pps   <= 1'b0;
        end
      endcase
    end
  end

  // LED stretch: reload on every accepted rise, lit through the final count of zero
  // so the indicator stays on for exactly LED_CYC cycles.
  always_ff @(posedge i_clk_25MHz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_led_cnt <= '0;
      r_led_on  <= 1'b0;
    end else if (w_accept) begin
      r_led_cnt <= LED_W'(LED_CYC - 1);
      r_led_on  <= 1'b1;
    end else if (r_led_cnt != '0) begin
      r_led_cnt <= r_led_cnt - 1'b1;
    end else begin
      r_led_on  <= 1'b0;
    end
  end

  assign o_pps   = r_pps;
  assign o_led   = r_led_on | r_pps;
  assign o_count = r_count;

`ifdef PPS_WATCHDOG_EN
  localparam int SAT_CYC   = PERIOD_CYC + TOL_CYC;
  localparam int EARLY_CYC = PERIOD_CYC - TOL_CYC;
  localparam int PER_W     = clog2(SAT_CYC + 1);

  logic [PER_W-1:0] r_per_cnt;
  logic             r_seen;
  logic             r_missing;
  logic             r_early;

  // Period watchdog: every rise (accepted or not) restarts the interval measurement.
  always_ff @(posedge i_clk_25MHz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_per_cnt <= '0;
      r_seen    <= 1'b0;
      r_missing <= 1'b0;
      r_early   <= 1'b0;
    end else if (w_rise) begin
      r_per_cnt <= '0;
      r_seen    <= 1'b1;
      r_missing <= 1'b0;
      r_early   <= r_seen & (r_per_cnt < PER_W'(EARLY_CYC));
    end else begin
      r_early <= 1'b0;
      if (r_per_cnt != PER_W'(SAT_CYC)) begin
        r_per_cnt <= r_per_cnt + 1'b1;
        if (r_per_cnt == PER_W'(SAT_CYC - 1)) r_missing <= 1'b1;
      end
    end
  end

  assign o_missing = r_missing;
  assign o_early   = r_early;
`else
  assign o_missing = 1'b0;
  assign o_early   = 1'b0;
`endif

endmodule

// File: tb/tb_pps_pulse_shaper.sv
// Bench for pps_pulse_shaper: directed scenarios plus randomised tick trains,
// every cycle compared against an event-time reference model.
module tb_pps_pulse_shaper;

  localparam int PULSE_CYC  = 25;
  localparam int PERIOD_CYC = 1750;
  localparam int TOL_CYC    = 25;
  localparam int LED_CYC    = 100;
  localparam int CNT_W      = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             tick = 1'b0;
  logic             pps;
  logic             led;
  logic [CNT_W-1:0] count;
  logic             missing;
  logic             early;

  int total = 0;
  int bad   = 0;

  // reference model state: times are edge indices since reset release
  int  n;
  bit  s1, s2;          // tick as sampled at the previous two edges
  bit  have_acc;
  int  last_acc;        // edge of last accepted pulse
  int  last_rise;       // edge of last detected rise (0 = reset)
  bit  seen;
  int  acc_cnt;
  bit  exp_early;
  int  pps_hi, led_hi;

  pps_pulse_shaper #(
    .PULSE_CYC  (PULSE_CYC),
    .PERIOD_CYC (PERIOD_CYC),
    .TOL_CYC    (TOL_CYC),
    .LED_CYC    (LED_CYC),
    .CNT_W      (CNT_W)
  ) dut (
    .i_clk_25MHz (clk),
    .i_rst_n     (rst_n),
    .i_tick      (tick),
    .o_pps       (pps),
    .o_led       (led),
    .o_count     (count),
    .o_missing   (missing),
    .o_early     (early)
  );

  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    n = 0; s1 = 0; s2 = 0;
    have_acc = 0; last_acc = 0; last_rise = 0;
    seen = 0; acc_cnt = 0; exp_early = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pps"},  {31'b0, pps},  32'd0);
    chk({tag, "_led"},  {31'b0, led},  32'd0);
    chk({tag, "_cnt"},  {28'b0, count}, 32'd0);
    chk({tag, "_miss"}, {31'b0, missing}, 32'd0);
    chk({tag, "_early"},{31'b0, early}, 32'd0);
  endtask

  // Called at a negedge; drives one cycle of tick, checks after the posedge,
  // returns at the following negedge.
  task automatic step(input bit v);
    bit rise;
    bit e_pps, e_led, e_miss, e_early;
    tick = v;
    @(posedge clk);
    n++;
    rise = s1 & ~s2;
    s2 = s1;
    s1 = v;
    e_early = 1'b0;
    if (rise) begin
      if (!have_acc || n >= last_acc + PULSE_CYC + 1) begin
        have_acc = 1;
        last_acc = n;
        acc_cnt++;
      end
      e_early = seen && ((n - 1 - last_rise) < (PERIOD_CYC - TOL_CYC));
      seen = 1;
      last_rise = n;
    end
    e_pps  = have_acc && (n - last_acc < PULSE_CYC);
    e_led  = have_acc && (n - last_acc < LED_CYC);
    e_miss = (n - last_rise) >= (PERIOD_CYC + TOL_CYC);
`ifndef PPS_WATCHDOG_EN
    e_miss  = 1'b0;
    e_early = 1'b0;
`endif
    #1;
    chk("pps",     {31'b0, pps},     {31'b0, e_pps});
    chk("led",     {31'b0, led},     {31'b0, e_led});
    chk("count",   {28'b0, count},   32'(acc_cnt % (1 << CNT_W)));
    chk("missing", {31'b0, missing}, {31'b0, e_miss});
    chk("early",   {31'b0, early},   {31'b0, e_early});
    if (pps) pps_hi++;
    if (led) led_hi++;
    @(negedge clk);
  endtask

  // Asserts reset asynchronously mid-cycle (no clock edge crossed), checks
  // outputs drop at once, holds a few cycles and releases at a negedge.
  task automatic do_reset(input string tag);
    #5;
    rst_n = 1'b0;
    tick  = 1'b0;
    #1;
    chk_zero({tag, "_async"});
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_zero({tag, "_hold"});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic ticks(input int width, input int gap);
    for (int i = 0; i < width; i++) step(1'b1);
    for (int i = 0; i < gap; i++) step(1'b0);
  endtask

  initial begin
    model_reset();
    // 1: reset and idle
    @(negedge clk);
    do_reset("init");
    for (int i = 0; i < 60; i++) step(1'b0);

    // 2: single 1-cycle tick
    pps_hi = 0; led_hi = 0;
    ticks(1, 150);
    chk("s2_width", 32'(pps_hi), 32'd25);
    chk("s2_led",   32'(led_hi), 32'd100);
    chk("s2_count", {28'b0, count}, 32'd1);

    // 3: tick held high 100 cycles
    pps_hi = 0;
    ticks(100, 120);
    chk("s3_width", 32'(pps_hi), 32'd25);
    chk("s3_count", {28'b0, count}, 32'd2);

    // 4: second tick 10 cycles after the first is ignored
    pps_hi = 0;
    ticks(1, 9);
    ticks(1, 150);
    chk("s4_width", 32'(pps_hi), 32'd25);
    chk("s4_count", {28'b0, count}, 32'd3);

    // 5: 17 nominal ticks wrap the counter, then a missing tick
    do_reset("s5");
    for (int k = 0; k < 17; k++) ticks(1, PERIOD_CYC - 1);
    chk("s5_wrap", {28'b0, count}, 32'd1);
    ticks(0, 1800);
`ifdef PPS_WATCHDOG_EN
    chk("s5_missing", {31'b0, missing}, 32'd1);
`endif
    ticks(1, 200);
    chk("s5_clear", {31'b0, missing}, 32'd0);

    // randomised tick trains around the short/long period boundaries
    for (int k = 0; k < 12; k++) begin
      int w, g;
      w = int'($urandom_range(1, 30));
      case ($urandom_range(0, 3))
        0: g = int'($urandom_range(1, 60));
        1: g = int'($urandom_range(1716, 1734));
        2: g = int'($urandom_range(1766, 1784));
        default: g = int'($urandom_range(30, 300));
      endcase
      ticks(w, (g > w) ? g - w : 1);
    end

    // 6: async reset mid-pulse, then a clean pulse
    ticks(1, 10);
    do_reset("s6");
    pps_hi = 0;
    ticks(1, 150);
    chk("s6_width", 32'(pps_hi), 32'd25);
    chk("s6_count", {28'b0, count}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
